// File: rtl/st2bus_pack.sv
// Packs a sop/eop byte stream into BUS-wide zero-padded words; a closing beat reaches the bus on the next edge when the output is free.
// Backpressure: st_ready drops only while a closed word waits behind a stalled output register.
module st2bus_pack #(
  parameter int ST    = 8,
  parameter int BUS   = 512,
  parameter int BEATS = BUS / ST,
  parameter int CW    = $clog2(BEATS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [ST-1:0]  st_data,
  input  logic           st_valid,
  input  logic           st_sop,
  input  logic           st_eop,
  output logic           st_ready,
  output logic [BUS-1:0] bus_data,
  output logic           bus_en,
  input  logic           bus_ready,
  output logic           bus_sop,
  output logic           bus_eop,
  output logic           bus_err,
  output logic [CW-1:0]  bus_nbeats,
  output logic [7:0]     bus_pkt_id,
  output logic [15:0]    drop_cnt
);

  typedef enum logic {IDLE, PKT} state_t;

  state_t         state, state_n;
  logic [BUS-1:0] acc_dat, acc_dat_n, ld_dat;
  logic [CW-1:0]  acc_cnt, acc_cnt_n, ld_cnt;
  logic           acc_closed, acc_closed_n;
  logic           acc_sop, acc_sop_n, acc_eop, acc_eop_n, acc_err, acc_err_n;
  logic [7:0]     acc_id, acc_id_n, ld_id, pkt_id, pkt_id_n;
  logic           ld_out, ld_sop, ld_eop, ld_err;
  logic           hold_vld, hold_vld_n, hold_eop, hold_eop_n;
  logic [ST-1:0]  hold_dat, hold_dat_n, put_dat;
  logic           put_vld, put_eop, put_new, put_err;
  logic [15:0]    drop_cnt_n;
  logic           out_free, move, accept;

  assign out_free = !bus_en || bus_ready;
  assign move     = acc_closed && out_free;
  // hold_vld parks the sop beat that truncated a packet while its last word waits for the bus
  assign st_ready = rst_n && !hold_vld && (!acc_closed || out_free);
  assign accept   = st_valid && st_ready;

  always_comb begin
    state_n      = state;
    acc_dat_n    = acc_dat;
    acc_cnt_n    = acc_cnt;
    acc_closed_n = acc_closed;
    acc_sop_n    = acc_sop;
    acc_eop_n    = acc_eop;
    acc_err_n    = acc_err;
    acc_id_n     = acc_id;
    pkt_id_n     = pkt_id;
    hold_vld_n   = hold_vld;
    hold_dat_n   = hold_dat;
    hold_eop_n   = hold_eop;
    drop_cnt_n   = drop_cnt;
    ld_out       = 1'b0;
    ld_dat       = acc_dat;
    ld_cnt       = acc_cnt;
    ld_sop       = acc_sop;
    ld_eop       = acc_eop;
    ld_err       = acc_err;
    ld_id        = acc_id;
    put_vld      = 1'b0;
    put_dat      = st_data;
    put_eop      = st_eop;
    put_new      = 1'b0;
    put_err      = 1'b0;

    if (move) begin
      ld_out       = 1'b1;
      acc_dat_n    = '0;
      acc_cnt_n    = '0;
      acc_closed_n = 1'b0;
      acc_sop_n    = 1'b0;
      acc_eop_n    = 1'b0;
      acc_err_n    = 1'b0;
    end

    if (hold_vld && move) begin
      hold_vld_n = 1'b0;
      put_vld    = 1'b1;
      put_dat    = hold_dat;
      put_eop    = hold_eop;
      put_new    = 1'b1;
    end

    if (accept) begin
      if (state == IDLE) begin
        if (st_sop) begin
          put_vld = 1'b1;
          put_new = 1'b1;
        end else if (drop_cnt != 16'hFFFF) begin
          drop_cnt_n = drop_cnt + 16'd1;
        end
      end else if (!st_sop) begin
        put_vld = 1'b1;
      end else if (acc_closed) begin
        // full word of the truncated packet is leaving now: flag it
        ld_err  = 1'b1;
        put_vld = 1'b1;
        put_new = 1'b1;
      end else if (acc_cnt == '0) begin
        put_vld = 1'b1;
        put_new = 1'b1;
        put_err = 1'b1;
      end else if (out_free) begin
        ld_out       = 1'b1;
        ld_err       = 1'b1;
        ld_eop       = 1'b0;
        acc_dat_n    = '0;
        acc_cnt_n    = '0;
        acc_closed_n = 1'b0;
        acc_sop_n    = 1'b0;
        acc_eop_n    = 1'b0;
        acc_err_n    = 1'b0;
        put_vld      = 1'b1;
        put_new      = 1'b1;
      end else begin
        acc_closed_n = 1'b1;
        acc_err_n    = 1'b1;
        hold_vld_n   = 1'b1;
        hold_dat_n   = st_data;
        hold_eop_n   = st_eop;
        state_n      = st_eop ? IDLE : PKT;
      end
    end

    if (put_vld) begin
      for (int k = 0; k < BEATS; k++) begin
        if (CW'(k) == acc_cnt_n) acc_dat_n[k*ST +: ST] = put_dat;
      end
      acc_cnt_n    = acc_cnt_n + CW'(1);
      acc_eop_n    = put_eop;
      acc_closed_n = put_eop || (acc_cnt_n == CW'(BEATS));
      if (put_new) begin
        acc_sop_n = 1'b1;
        acc_err_n = put_err;
        acc_id_n  = pkt_id;
        pkt_id_n  = pkt_id + 8'd1;
      end
      state_n = put_eop ? IDLE : PKT;
      // bypass straight into the output register so the closing beat shows up one edge later
      if (acc_closed_n && !ld_out && out_free) begin
        ld_out       = 1'b1;
        ld_dat       = acc_dat_n;
        ld_cnt       = acc_cnt_n;
        ld_sop       = acc_sop_n;
        ld_eop       = acc_eop_n;
        ld_err       = acc_err_n;
        ld_id        = acc_id_n;
        acc_dat_n    = '0;
        acc_cnt_n    = '0;
        acc_closed_n = 1'b0;
        acc_sop_n    = 1'b0;
        acc_eop_n    = 1'b0;
        acc_err_n    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_dat    <= '0;
      acc_cnt    <= '0;
      acc_closed <= 1'b0;
      acc_sop    <= 1'b0;
      acc_eop    <= 1'b0;
      acc_err    <= 1'b0;
      acc_id     <= '0;
      pkt_id     <= '0;
      hold_vld   <= 1'b0;
      hold_dat   <= '0;
      hold_eop   <= 1'b0;
      drop_cnt   <= '0;
      bus_data   <= '0;
      bus_en     <= 1'b0;
      bus_sop    <= 1'b0;
      bus_eop    <= 1'b0;
      bus_err    <= 1'b0;
      bus_nbeats <= '0;
      bus_pkt_id <= '0;
    end else begin
      acc_dat    <= acc_dat_n;
      acc_cnt    <= acc_cnt_n;
      acc_closed <= acc_closed_n;
      acc_sop    <= acc_sop_n;
      acc_eop    <= acc_eop_n;
      acc_err    <= acc_err_n;
      acc_id     <= acc_id_n;
      pkt_id     <= pkt_id_n;
      hold_vld   <= hold_vld_n;
      hold_dat   <= hold_dat_n;
      hold_eop   <= hold_eop_n;
      drop_cnt   <= drop_cnt_n;
      if (ld_out) begin
        bus_en     <= 1'b1;
        bus_data   <= ld_dat;
        bus_nbeats <= ld_cnt;
        bus_sop    <= ld_sop;
        bus_eop    <= ld_eop;
        bus_err    <= ld_err;
        bus_pkt_id <= ld_id;
      end else if (bus_ready) begin
        bus_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_st2bus_pack.sv
// Scoreboard bench for st2bus_pack: expected words are queued as beats are driven and popped as the bus accepts them.
module tb_st2bus_pack;
  localparam int BEATS = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   st_data;
  logic         st_valid, st_sop, st_eop, st_ready;
  logic [511:0] bus_data;
  logic         bus_en, bus_ready, bus_sop, bus_eop, bus_err;
  logic [6:0]   bus_nbeats;
  logic [7:0]   bus_pkt_id;
  logic [15:0]  drop_cnt;

  st2bus_pack dut (
    .clk(clk), .rst_n(rst_n),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop), .st_ready(st_ready),
    .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready), .bus_sop(bus_sop), .bus_eop(bus_eop),
    .bus_err(bus_err), .bus_nbeats(bus_nbeats), .bus_pkt_id(bus_pkt_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] dat;
    logic [6:0]   nb;
    logic         sop;
    logic         eop;
    logic         err;
    logic [7:0]   id;
  } word_t;

  word_t      exp_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         words_seen = 0;
  logic [7:0] exp_id;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus_en && bus_ready) begin
      word_t w;
      words_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 512'(bus_pkt_id), 512'(8'hFF));
      end else begin
        w = exp_q.pop_front();
        chk("data", bus_data, w.dat);
        chk("nbeats", 512'(bus_nbeats), 512'(w.nb));
        chk("sop", 512'(bus_sop), 512'(w.sop));
        chk("eop", 512'(bus_eop), 512'(w.eop));
        chk("err", 512'(bus_err), 512'(w.err));
        chk("pkt_id", 512'(bus_pkt_id), 512'(w.id));
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic s, input logic e);
    int n;
    n = 0;
    st_data = d; st_sop = s; st_eop = e; st_valid = 1'b1;
    @(negedge clk);
    while (!st_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("st_ready_timeout", 512'(st_ready), 512'(1));
    @(posedge clk);
    #1;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
  endtask

  task automatic send_pkt(input int len, input int base, input bit trunc);
    word_t      w;
    int         cnt;
    bit         first;
    logic [7:0] v;
    logic       e;
    w = '0; cnt = 0; first = 1'b1;
    for (int i = 0; i < len; i++) begin
      v = 8'(base + i);
      e = (i == len - 1) && !trunc;
      w.dat[cnt*8 +: 8] = v;
      cnt++;
      if (cnt == BEATS || e) begin
        w.nb = 7'(cnt); w.sop = first; w.eop = e; w.err = 1'b0; w.id = exp_id;
        exp_q.push_back(w);
        w = '0; cnt = 0; first = 1'b0;
      end
      drive_beat(v, i == 0, e);
    end
    if (trunc && cnt > 0) begin
      w.nb = 7'(cnt); w.sop = first; w.eop = 1'b0; w.err = 1'b1; w.id = exp_id;
      exp_q.push_back(w);
    end
    exp_id = exp_id + 8'd1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 512'(exp_q.size()), 512'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0; st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    bus_ready = 1'b1; exp_id = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_st_ready", 512'(st_ready), 512'(0));
    chk("rst_bus_en", 512'(bus_en), 512'(0));
    chk("rst_bus_data", bus_data, 512'(0));
    chk("rst_drop_cnt", 512'(drop_cnt), 512'(0));
    chk("rst_pkt_id", 512'(bus_pkt_id), 512'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_st_ready", 512'(st_ready), 512'(1));
    @(posedge clk); #1;

    // T1 / T2: full and partial-last-word packets
    send_pkt(128, 0, 1'b0);
    wait_drain();
    send_pkt(100, 8'h10, 1'b0);
    wait_drain();

    // T3: output stalled for 200 cycles, everything must be held
    fork
      send_pkt(128, 8'h40, 1'b0);
      begin
        bus_ready = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("t3_st_ready", 512'(st_ready), 512'(0));
        chk("t3_bus_en", 512'(bus_en), 512'(1));
        chk("t3_held_nbeats", 512'(bus_nbeats), 512'(64));
        chk("t3_pending", 512'(exp_q.size()), 512'(2));
        bus_ready = 1'b1;
      end
    join
    wait_drain();

    // T4: beats outside a packet are counted and dropped
    for (int i = 0; i < 5; i++) drive_beat(8'hEE, 1'b0, 1'b0);
    chk("t4_drop_cnt", 512'(drop_cnt), 512'(5));
    send_pkt(20, 8'h20, 1'b0);
    wait_drain();
    chk("t4_drop_cnt_after", 512'(drop_cnt), 512'(5));

    // T6: reset mid-packet discards the partial word
    seen = words_seen;
    for (int i = 0; i < 40; i++) drive_beat(8'(i), i == 0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_st_ready", 512'(st_ready), 512'(0));
    chk("t6_rst_bus_en", 512'(bus_en), 512'(0));
    @(posedge clk); #1; rst_n = 1'b1; exp_id = 8'd0;
    repeat (3) @(negedge clk);
    chk("t6_no_word", 512'(words_seen), 512'(seen));
    chk("t6_drop_cnt", 512'(drop_cnt), 512'(0));
    @(posedge clk); #1;

    // T5: 1-beat and exact-64 packets, then a packet truncated by a new sop
    send_pkt(3, 8'h50, 1'b0);
    send_pkt(1, 8'h60, 1'b0);
    send_pkt(64, 8'h70, 1'b0);
    send_pkt(10, 8'hA0, 1'b1);
    send_pkt(5, 8'hC0, 1'b0);
    wait_drain();

    chk("total_words", 512'(words_seen), 512'(12));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
